trigger_capture_unit: RTL

Upstream stage of the FIFO-to-UART readout path. Synchronises the 3 probe inputs, waits for a masked trigger condition, then writes one 3-bit sample per sample tick into the capture FIFO until the FIFO reports write-full, and holds until the controller re-arms it. It is driven by the controller's trigger sync-reset and mask outputs, and fills the FIFO that the controller drains to the UART.

---
 rtl/trigger_capture_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/trigger_capture_unit.sv
// trigger_capture_unit: probe synchroniser, masked trigger detector and
// sample-rate capture writer feeding the readout FIFO.
module trigger_capture_unit #(
  parameter int CH_WIDTH  = 3,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_rst,
  input  logic [CH_WIDTH-1:0]  trig_mask,
  input  logic [1:0]           trig_mode,
  input  logic [DIV_WIDTH-1:0] sample_div,
  input  logic [CH_WIDTH-1:0]  probe_in,
  input  logic                 FIFO_wrfull,
  output logic                 FIFO_wrreq,
  output logic [CH_WIDTH-1:0]  FIFO_data,
  output logic                 armed,
  output logic                 triggered,
  output logic [1:0]           state_debug
);

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMED    = 2'b01,
    CAPTURE  = 2'b10,
    DONE     = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [CH_WIDTH-1:0]  sync1_q, sync2_q, prev_q;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 wrreq_q, wrreq_d;
  logic [CH_WIDTH-1:0]  data_q, data_d;
  logic [CH_WIDTH-1:0]  rise, fall, any_edge, cond;
  logic                 trig_hit;
  logic                 tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= probe_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    rise     = sync2_q & ~prev_q;
    fall     = ~sync2_q & prev_q;
    any_edge = sync2_q ^ prev_q;
    cond     = '0;
    unique case (trig_mode)
      2'b00: cond = rise;
      2'b01: cond = fall;
      2'b10: cond = any_edge;
      2'b11: cond = sync2_q;
    endcase
    // An empty mask means free-run: trigger immediately.
    trig_hit = (trig_mask == '0) | (|(cond & trig_mask));
  end

  assign tick = (div_q >= sample_div);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    wrreq_d = 1'b0;
    data_d  = data_q;
    if (sync_rst) begin
      state_d = DISARMED;
      div_d   = '0;
    end else begin
      unique case (state_q)
        DISARMED: state_d = ARMED;
        ARMED: begin
          if (trig_hit) begin
            div_d = '0;
            if (FIFO_wrfull) begin
              state_d = DONE;
            end else begin
              state_d = CAPTURE;
              wrreq_d = 1'b1;
              data_d  = sync2_q;
            end
          end
        end
        CAPTURE: begin
          if (FIFO_wrfull) begin
            state_d = DONE;
          end else if (tick) begin
            div_d   = '0;
            wrreq_d = 1'b1;
            data_d  = sync2_q;
          end else begin
            div_d = div_q + DIV_WIDTH'(1);
          end
        end
        DONE: state_d = DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DISARMED;
      div_q   <= '0;
      wrreq_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      wrreq_q <= wrreq_d;
      data_q  <= data_d;
    end
  end

  assign FIFO_wrreq  = wrreq_q;
  assign FIFO_data   = data_q;
  assign armed       = (state_q == ARMED);
  assign triggered   = state_q[1];
  assign state_debug = state_q;

endmodule
